// File: rtl/bus_pkg.sv
// Shared definitions for the mem_valid/mem_ready bus initiator.
package bus_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  localparam logic [3:0] STRB_READ = 4'b0000;

  localparam int unsigned DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StReq  = REQ,
    StRsp  = RSP
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + One;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_bus_initiator.sv
// Single-transaction initiator for the mem_valid/mem_ready peripheral bus with timeout
// abort and transaction statistics.
module mem_bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned TXN_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [31:0]              cmd_addr_i,
  input  logic [31:0]              cmd_wdata_i,
  input  logic [3:0]               cmd_wstrb_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     mem_valid_o,
  input  logic                     mem_ready_i,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  output logic [3:0]               mem_wstrb_o,
  input  logic [31:0]              mem_rdata_i,
  output logic [TXN_CNT_WIDTH-1:0] txn_count_o,
  output logic [7:0]               timeout_count_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);
  localparam logic [TXN_CNT_WIDTH-1:0] TxnOne = TXN_CNT_WIDTH'(1);

  state_e                   state_q;
  logic                     cmd_ready_q;
  logic                     mem_valid_q;
  logic [31:0]              mem_addr_q;
  logic [31:0]              mem_wdata_q;
  logic [3:0]               mem_wstrb_q;
  logic                     rsp_valid_q;
  logic [31:0]              rsp_rdata_q;
  logic                     rsp_err_q;
  logic [TXN_CNT_WIDTH-1:0] txn_q;
  logic [TmoW-1:0]          tmo_q;
  logic                     tmo_expire;

  // An acknowledge in the expiry cycle takes priority over the abort.
  assign tmo_expire = (state_q == StReq) && !mem_ready_i && (tmo_q == TmoLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      txn_q       <= '0;
      tmo_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            mem_addr_q  <= cmd_addr_i;
            mem_wdata_q <= cmd_wdata_i;
            mem_wstrb_q <= cmd_wstrb_i;
            mem_valid_q <= 1'b1;
            cmd_ready_q <= 1'b0;
            tmo_q       <= '0;
            state_q     <= StReq;
          end
        end
        StReq: begin
          tmo_q <= tmo_q + TmoOne;
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            rsp_rdata_q <= (mem_wstrb_q == STRB_READ) ? mem_rdata_i : '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            txn_q       <= txn_q + TxnOne;
            state_q     <= StRsp;
          end else if (tmo_expire) begin
            mem_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRsp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
          mem_valid_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .Width (8)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (tmo_expire),
    .count_o (timeout_count_o)
  );

  assign cmd_ready_o = cmd_ready_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign txn_count_o = txn_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator: reads, writes, timeouts, saturation and reset abort.
module tb_mem_bus_initiator;

  logic        clk;
  logic        reset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_wstrb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  logic [15:0] txn_count_o;
  logic [7:0]  timeout_count_o;

  int checks;
  int errors;

  mem_bus_initiator #(
    .TIMEOUT_CYCLES (64),
    .TXN_CNT_WIDTH  (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_addr_i      (cmd_addr_i),
    .cmd_wdata_i     (cmd_wdata_i),
    .cmd_wstrb_i     (cmd_wstrb_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_err_o       (rsp_err_o),
    .mem_valid_o     (mem_valid_o),
    .mem_ready_i     (mem_ready_i),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_wstrb_o     (mem_wstrb_o),
    .mem_rdata_i     (mem_rdata_i),
    .txn_count_o     (txn_count_o),
    .timeout_count_o (timeout_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single accepting edge; returns in the first REQ cycle.
  task automatic do_cmd(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    int n;
    n = 0;
    while (!cmd_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready_o) check("cmd_ready_wait", {31'b0, cmd_ready_o}, 32'd1);
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_wstrb_i = strb;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic consume();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("rsp_valid_after_consume", {31'b0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    int hc;
    int n;
    int exp_txn;
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_wstrb_i = '0;
    rsp_ready_i = 1'b0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    check("rst_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_txn", {16'b0, txn_count_o}, 32'd0);
    check("rst_tmo", {24'b0, timeout_count_o}, 32'd0);

    // Read 0x8, one-cycle responder
    do_cmd(32'h0000_0008, 32'h0, 4'h0);
    check("rd_c1_mem_valid", {31'b0, mem_valid_o}, 32'd1);
    check("rd_c1_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
    check("rd_c1_addr", mem_addr_o, 32'h0000_0008);
    tick();
    check("rd_c2_mem_valid", {31'b0, mem_valid_o}, 32'd1);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h0000_0001;
    tick();
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'hBAD0_BAD0;
    check("rd_c3_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    check("rd_c3_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    check("rd_rdata", rsp_rdata_o, 32'h0000_0001);
    check("rd_err", {31'b0, rsp_err_o}, 32'd0);
    check("rd_txn", {16'b0, txn_count_o}, 32'd1);
    consume();
    check("rd_back_idle", {31'b0, cmd_ready_o}, 32'd1);

    // Write 0x200 to 0x0, ack after 5 cycles
    do_cmd(32'h0000_0000, 32'h0000_0200, 4'hF);
    cmd_wdata_i = 32'h1234_5678;
    cmd_wstrb_i = 4'h3;
    for (int i = 0; i < 5; i++) begin
      check("wr_mem_valid", {31'b0, mem_valid_o}, 32'd1);
      check("wr_wdata_stable", mem_wdata_o, 32'h0000_0200);
      check("wr_wstrb_stable", {28'b0, mem_wstrb_o}, 32'hF);
      tick();
    end
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    mem_ready_i = 1'b0;
    check("wr_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    check("wr_rdata_zero", rsp_rdata_o, 32'd0);
    check("wr_err", {31'b0, rsp_err_o}, 32'd0);
    check("wr_txn", {16'b0, txn_count_o}, 32'd2);
    consume();

    // Timeout on unmapped address
    mem_rdata_i = 32'h5555_AAAA;
    do_cmd(32'hDEAD_0000, 32'h0, 4'h0);
    hc = 0;
    while (mem_valid_o && hc < 200) begin
      hc++;
      tick();
    end
    check("tmo_high_cycles", hc, 32'd64);
    check("tmo_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    check("tmo_err", {31'b0, rsp_err_o}, 32'd1);
    check("tmo_rdata", rsp_rdata_o, 32'd0);
    check("tmo_count", {24'b0, timeout_count_o}, 32'd1);
    check("tmo_txn_unchanged", {16'b0, txn_count_o}, 32'd2);
    consume();

    // Ack in the expiry cycle (64th REQ cycle) wins
    do_cmd(32'h0000_0010, 32'h0, 4'h0);
    repeat (63) tick();
    check("race_still_valid", {31'b0, mem_valid_o}, 32'd1);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    tick();
    mem_ready_i = 1'b0;
    check("race_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    check("race_err", {31'b0, rsp_err_o}, 32'd0);
    check("race_rdata", rsp_rdata_o, 32'hCAFE_F00D);
    check("race_txn", {16'b0, txn_count_o}, 32'd3);
    check("race_tmo", {24'b0, timeout_count_o}, 32'd1);
    consume();

    // 300 forced timeouts saturate the timeout counter
    for (int i = 0; i < 300; i++) begin
      do_cmd(32'hDEAD_0100, 32'h0, 4'h0);
      n = 0;
      while (!rsp_valid_o && n < 100) begin
        tick();
        n++;
      end
      if (!rsp_valid_o) check("sat_rsp_wait", {31'b0, rsp_valid_o}, 32'd1);
      if (i == 253) check("sat_tmo_255", {24'b0, timeout_count_o}, 32'd255);
      consume();
    end
    check("sat_tmo_final", {24'b0, timeout_count_o}, 32'd255);
    check("sat_txn_unchanged", {16'b0, txn_count_o}, 32'd3);
    exp_txn = 3;

    // Back-to-back with stalled response and spurious acks
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    check("spur_idle_txn", {16'b0, txn_count_o}, exp_txn);
    check("spur_idle_rsp", {31'b0, rsp_valid_o}, 32'd0);
    cmd_addr_i  = 32'h0000_0020;
    cmd_wstrb_i = 4'h0;
    cmd_valid_i = 1'b1;
    tick();
    cmd_addr_i = 32'h0000_0024;
    check("b2b_req1_addr", mem_addr_o, 32'h0000_0020);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h0000_0011;
    tick();
    mem_ready_i = 1'b0;
    exp_txn++;
    check("b2b_rsp1_rdata", rsp_rdata_o, 32'h0000_0011);
    for (int i = 0; i < 10; i++) begin
      check("b2b_stall_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
      check("b2b_stall_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
      check("b2b_stall_mem_valid", {31'b0, mem_valid_o}, 32'd0);
      mem_ready_i = (i == 3);
      tick();
    end
    mem_ready_i = 1'b0;
    check("b2b_spur_rsp_txn", {16'b0, txn_count_o}, exp_txn);
    check("b2b_rdata_held", rsp_rdata_o, 32'h0000_0011);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("b2b_gap_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    check("b2b_gap_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    tick();
    cmd_valid_i = 1'b0;
    check("b2b_req2_valid", {31'b0, mem_valid_o}, 32'd1);
    check("b2b_req2_addr", mem_addr_o, 32'h0000_0024);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h0000_0022;
    tick();
    mem_ready_i = 1'b0;
    exp_txn++;
    check("b2b_rsp2_rdata", rsp_rdata_o, 32'h0000_0022);
    check("b2b_txn", {16'b0, txn_count_o}, exp_txn);
    consume();

    // Asynchronous reset in the middle of REQ
    do_cmd(32'h0000_0030, 32'h0, 4'h0);
    tick();
    check("rst_mid_valid_before", {31'b0, mem_valid_o}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    check("rst_mid_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_mid_txn", {16'b0, txn_count_o}, 32'd0);
    check("rst_mid_tmo", {24'b0, timeout_count_o}, 32'd0);
    check("rst_mid_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_idle", {31'b0, mem_valid_o}, 32'd0);
    do_cmd(32'h0000_0040, 32'h0, 4'h0);
    check("post_rst_addr", mem_addr_o, 32'h0000_0040);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h0000_00AB;
    tick();
    mem_ready_i = 1'b0;
    check("post_rst_rdata", rsp_rdata_o, 32'h0000_00AB);
    check("post_rst_err", {31'b0, rsp_err_o}, 32'd0);
    check("post_rst_txn", {16'b0, txn_count_o}, 32'd1);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Bus initiator (master) for the on-chip mem_valid/mem_ready peripheral bus; the requesting end of the protocol that the OCD, timer and other register peripherals answer.
- Accepts single read/write commands on a valid/ready command port, issues one bus transaction, and returns read data or a timeout error on a valid/ready response port.
- Sits between a host-side source (debug UART bridge or sequencer) and the peripheral address space.
- Keeps transaction and timeout statistics.

Parameters:
- TIMEOUT_CYCLES, 64: cycles mem_valid_o may stay high without mem_ready_i before the transaction is aborted; legal range 2..65535.
- TXN_CNT_WIDTH, 16: width of the completed-transaction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_addr_i  in  32  byte address
- cmd_wdata_i  in  32  write data
- cmd_wstrb_i  in  4  byte strobes; 4'b0000 means read
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data; 0 for writes and on error
- rsp_err_o  out  1  transaction timed out
- mem_valid_o  out  1  bus request
- mem_ready_i  in  1  responder acknowledge
- mem_addr_o  out  32  bus address
- mem_wdata_o  out  32  bus write data
- mem_wstrb_o  out  4  bus strobes
- mem_rdata_i  in  32  responder read data, valid only while mem_ready_i is high
- txn_count_o  out  TXN_CNT_WIDTH  completed transactions; wraps
- timeout_count_o  out  8  timed-out transactions; saturates at 255

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0 except cmd_ready_o=1. A reset during REQ drops mem_valid_o immediately and discards the command.
- FSM states:
  - IDLE: cmd_ready_o=1. When cmd_valid_i is high, register addr/wdata/wstrb onto mem_*_o, set mem_valid_o<=1, clear the timeout counter, go to REQ.
  - REQ: cmd_ready_o=0 and mem_valid_o=1, with mem_addr_o/mem_wdata_o/mem_wstrb_o held stable. The timeout counter increments every cycle.
    - If mem_ready_i: mem_valid_o<=0; rsp_rdata_o<=mem_rdata_i when wstrb==0, else 0; rsp_err_o<=0; rsp_valid_o<=1; txn_count_o+1; go to RSP.
    - Else, if the counter reaches TIMEOUT_CYCLES-1: mem_valid_o<=0, rsp_rdata_o<=0, rsp_err_o<=1, rsp_valid_o<=1, timeout_count_o+1 (saturating), go to RSP.
    - If mem_ready_i arrives in the same cycle as expiry, ready wins: normal completion, no error.
  - RSP: rsp_valid_o held with data/err stable until rsp_ready_i. On rsp_ready_i: rsp_valid_o<=0, go to IDLE.
- Latency with a one-cycle responder:
  - Cycle 0: command accepted.
  - Cycle 1: mem_valid_o high.
  - Cycle 2: mem_ready_i.
  - Cycle 3: rsp_valid_o high.
  - Minimum command-to-command spacing is 4 cycles with rsp_ready_i tied high.
- Bus rules:
  - mem_valid_o goes low in the cycle after mem_ready_i is sampled high. It is never high for two consecutive transactions without at least one low cycle in between; responders re-arm their single-ack logic on that gap.
  - mem_ready_i outside REQ is ignored and is not counted.
  - mem_rdata_i is sampled only in the cycle mem_ready_i is high.
- cmd_* inputs are ignored outside IDLE.
- txn_count_o wraps from 2^TXN_CNT_WIDTH-1 to 0. It counts acknowledged transactions only.
- Width rules: the timeout counter is $clog2(TIMEOUT_CYCLES)+1 bits. No address decoding or alignment checks; the address passes through unchanged.

Decomposition:
- Shared package bus_pkg holds:
  - localparams for state encoding (IDLE=2'd0, REQ=2'd1, RSP=2'd2);
  - STRB_READ=4'b0000;
  - the default timeout value.
- Optional sub-module sat_counter (parameterised width, increment, saturate) serves timeout_count_o. Everything else stays in the single module.

Test Plan:
- Read from the OCD responder at 0x0000_0008 with a one-cycle ack returning 0x0000_0001 -> mem_valid_o high cycles 1-2, then rsp_valid_o=1, rsp_rdata_o=0x1, rsp_err_o=0, txn_count_o=1.
- Write 0x0000_0200 to 0x0000_0000 with wstrb 4'hF, ack after 5 cycles -> mem_wdata_o/mem_wstrb_o stable throughout REQ, rsp_rdata_o=0, rsp_err_o=0.
- Read from unmapped 0xDEAD_0000 with no ack, TIMEOUT_CYCLES=64 -> mem_valid_o high exactly 64 cycles, rsp_err_o=1, rsp_rdata_o=0, timeout_count_o=1, txn_count_o unchanged.
- Ack coincident with the timeout-expiry cycle -> rsp_err_o=0 and data captured; then 300 forced timeouts -> timeout_count_o saturates at 255.
- Back-to-back commands with rsp_ready_i stalled 10 cycles -> cmd_ready_o=0 until the response is consumed, mem_valid_o low at least 1 cycle between requests, and spurious mem_ready_i pulses in IDLE/RSP are ignored.
- Assert reset mid-REQ -> mem_valid_o=0 in the same cycle (async), rsp_valid_o=0, counters=0; a command issued after release completes normally.
